// File: rtl/fft_sample_loader_if.sv
// ============================================================================
// Module   : fft_sample_loader_if
// Brief    : Sample stream (valid/ready + flush) between front end and loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fft_sample_loader_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_real;
    logic [N-1:0] in_imag;
    logic         flush;

    modport master (
        output in_valid,
        output in_real,
        output in_imag,
        output flush,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_real,
        input  in_imag,
        input  flush,
        output in_ready
    );
endinterface

`default_nettype wire

// File: rtl/fft_sample_loader.sv
// ============================================================================
// Module   : fft_sample_loader
// Brief    : Writes one frame of complex samples (zero-padded) into the FFT
//            input RAM pair, then holds startfft until donefft.
//            Optional macro FFT_LOADER_SCALE_EN: magnitude >> SCALE_SHIFT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fft_sample_loader #(
    parameter int N           = 32,
    parameter int Q           = 16,
    parameter int NPTS        = 512,
    parameter int AW          = 9,
    parameter int SCALE_SHIFT = 9
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start_load,
    fft_sample_loader_if.slave     s_if,
    output logic      [AW-1:0]     addr_fft_real,
    output logic      [AW-1:0]     addr_fft_imag,
    output logic      [N-1:0]      data_fft_real,
    output logic      [N-1:0]      data_fft_imag,
    output logic                   wren_fft,
    input  wire logic              donefft,
    output logic                   startfft,
    output logic                   done_load,
    output logic      [AW:0]       sample_count,
    output logic      [N-1:0]      clk_count_load
);

    if ((1 << AW) != NPTS || Q >= N || SCALE_SHIFT >= N) begin : g_param_check
        $error("fft_sample_loader: inconsistent parameters");
    end

    localparam logic [AW:0] C_LAST_IDX = (AW+1)'(NPTS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACCEPT   = 3'd1,
        S_PAD      = 3'd2,
        S_KICK     = 3'd3,
        S_WAIT_FFT = 3'd4
    } state_t;

    state_t         state_q;
    logic           in_ready_q;
    logic           wren_q;
    logic [AW-1:0]  addr_q;
    logic [N-1:0]   data_real_q;
    logic [N-1:0]   data_imag_q;
    logic           startfft_q;
    logic           done_load_q;
    logic [AW:0]    sample_count_q;
    logic [N-1:0]   clk_count_q;

    logic [N-2:0]   mag_real_d;
    logic [N-2:0]   mag_imag_d;
    logic [N-1:0]   data_real_d;
    logic [N-1:0]   data_imag_d;

    // Sign is dropped whenever the (possibly scaled) magnitude is zero.
    always_comb begin
`ifdef FFT_LOADER_SCALE_EN
        mag_real_d = s_if.in_real[N-2:0] >> SCALE_SHIFT;
        mag_imag_d = s_if.in_imag[N-2:0] >> SCALE_SHIFT;
`else
        mag_real_d = s_if.in_real[N-2:0];
        mag_imag_d = s_if.in_imag[N-2:0];
`endif
        data_real_d = {s_if.in_real[N-1] & (|mag_real_d), mag_real_d};
        data_imag_d = {s_if.in_imag[N-1] & (|mag_imag_d), mag_imag_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            in_ready_q     <= 1'b0;
            wren_q         <= 1'b0;
            addr_q         <= '0;
            data_real_q    <= '0;
            data_imag_q    <= '0;
            startfft_q     <= 1'b0;
            done_load_q    <= 1'b0;
            sample_count_q <= '0;
            clk_count_q    <= '0;
        end else begin
            wren_q      <= 1'b0;
            done_load_q <= 1'b0;
            if (state_q != S_IDLE) begin
                clk_count_q <= clk_count_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_load) begin
                        sample_count_q <= '0;
                        clk_count_q    <= '0;
                        in_ready_q     <= 1'b1;
                        state_q        <= S_ACCEPT;
                    end
                end

                S_ACCEPT: begin
                    if (s_if.in_valid) begin
                        wren_q         <= 1'b1;
                        addr_q         <= sample_count_q[AW-1:0];
                        data_real_q    <= data_real_d;
                        data_imag_q    <= data_imag_d;
                        sample_count_q <= sample_count_q + 1'b1;
                    end
                    // A full frame wins over a simultaneous flush: nothing left to pad.
                    if (s_if.in_valid && sample_count_q == C_LAST_IDX) begin
                        in_ready_q <= 1'b0;
                        state_q    <= S_KICK;
                    end else if (s_if.flush) begin
                        in_ready_q <= 1'b0;
                        state_q    <= S_PAD;
                    end
                end

                S_PAD: begin
                    wren_q         <= 1'b1;
                    addr_q         <= sample_count_q[AW-1:0];
                    data_real_q    <= '0;
                    data_imag_q    <= '0;
                    sample_count_q <= sample_count_q + 1'b1;
                    if (sample_count_q == C_LAST_IDX) begin
                        state_q <= S_KICK;
                    end
                end

                S_KICK: begin
                    startfft_q <= 1'b1;
                    state_q    <= S_WAIT_FFT;
                end

                S_WAIT_FFT: begin
                    if (donefft) begin
                        startfft_q  <= 1'b0;
                        done_load_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_if.in_ready   = in_ready_q;
    assign addr_fft_real   = addr_q;
    assign addr_fft_imag   = addr_q;
    assign data_fft_real   = data_real_q;
    assign data_fft_imag   = data_imag_q;
    assign wren_fft        = wren_q;
    assign startfft        = startfft_q;
    assign done_load       = done_load_q;
    assign sample_count    = sample_count_q;
    assign clk_count_load  = clk_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_sample_loader.sv
// ============================================================================
// Module   : tb_fft_sample_loader
// Brief    : Scoreboard bench for fft_sample_loader (full, short, flush, gaps,
//            reset mid-frame, zero-sample frame).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fft_sample_loader;

    localparam int N           = 32;
    localparam int NPTS        = 512;
    localparam int AW          = 9;
    localparam int SCALE_SHIFT = 9;

    typedef logic [2*AW+2*N-1:0] wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_load = 1'b0;
    logic          donefft = 1'b0;
    logic [AW-1:0] addr_fft_real, addr_fft_imag;
    logic [N-1:0]  data_fft_real, data_fft_imag;
    logic          wren_fft, startfft, done_load;
    logic [AW:0]   sample_count;
    logic [N-1:0]  clk_count_load;

    fft_sample_loader_if #(.N(N)) s_if ();

    fft_sample_loader #(
        .N(N), .Q(16), .NPTS(NPTS), .AW(AW), .SCALE_SHIFT(SCALE_SHIFT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_load     (start_load),
        .s_if           (s_if),
        .addr_fft_real  (addr_fft_real),
        .addr_fft_imag  (addr_fft_imag),
        .data_fft_real  (data_fft_real),
        .data_fft_imag  (data_fft_imag),
        .wren_fft       (wren_fft),
        .donefft        (donefft),
        .startfft       (startfft),
        .done_load      (done_load),
        .sample_count   (sample_count),
        .clk_count_load (clk_count_load)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  exp_count = 0;
    int  cyc_s = 0;
    wr_t exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] x);
        logic [N-2:0] m;
        m = x[N-2:0];
`ifdef FFT_LOADER_SCALE_EN
        m = m >> SCALE_SHIFT;
`endif
        return {x[N-1] && (m != '0), m};
    endfunction

    function automatic wr_t mk(input int a, input logic [N-1:0] re, input logic [N-1:0] im);
        return {AW'(a), AW'(a), re, im};
    endfunction

    always @(negedge clk) begin
        if (wren_fft === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                check("ram_write", {addr_fft_real, addr_fft_imag, data_fft_real, data_fft_imag},
                      exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pads();
        for (int a = exp_count; a < NPTS; a++) exp_q.push_back(mk(a, '0, '0));
        exp_count = NPTS;
    endtask

    task automatic start_frame();
        start_load = 1'b1;
        step();
        start_load = 1'b0;
        cyc_s      = cyc;
        exp_count  = 0;
        check("ready_after_start", s_if.in_ready, 1);
        check("count_cleared", sample_count, 0);
        check("clkcnt_cleared", clk_count_load, 0);
    endtask

    task automatic send(input logic [N-1:0] re, input logic [N-1:0] im, input logic fl);
        bit done = 0;
        s_if.in_valid = 1'b1;
        s_if.in_real  = re;
        s_if.in_imag  = im;
        s_if.flush    = fl;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (s_if.in_ready === 1'b1) begin
                exp_q.push_back(mk(exp_count, model(re), model(im)));
                exp_count++;
                if (fl) push_pads();
                done = 1;
            end
            step();
        end
        if (!done) check("send_timeout", 0, 1);
        s_if.in_valid = 1'b0;
        s_if.flush    = 1'b0;
    endtask

    task automatic flush_only();
        s_if.flush = 1'b1;
        @(negedge clk);
        if (s_if.in_ready === 1'b1) push_pads();
        step();
        s_if.flush = 1'b0;
    endtask

    task automatic finish_frame(input int lat);
        bit seen = 0;
        for (int t = 0; t < 3000 && !seen; t++) begin
            @(negedge clk);
            if (startfft === 1'b1) seen = 1;
        end
        if (!seen) begin
            check("startfft_timeout", 0, 1);
            return;
        end
        check("count_full", sample_count, NPTS);
        check("all_writes_seen", exp_q.size(), 0);
        step();
        repeat (lat) step();
        check("startfft_held", startfft, 1);
        check("no_early_done", done_load, 0);
        donefft = 1'b1;
        step();
        donefft = 1'b0;
        check("done_pulse", done_load, 1);
        check("startfft_dropped", startfft, 0);
        check("clk_count", clk_count_load, cyc - cyc_s);
        step();
        check("done_one_cycle", done_load, 0);
        check("clk_count_held", clk_count_load, cyc - 1 - cyc_s);
        check("idle_not_ready", s_if.in_ready, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", s_if.in_ready, 0);
        check("rst_wren", wren_fft, 0);
        check("rst_addr", {addr_fft_real, addr_fft_imag}, 0);
        check("rst_data", {data_fft_real, data_fft_imag}, 0);
        check("rst_startfft", startfft, 0);
        check("rst_done", done_load, 0);
        check("rst_count", sample_count, 0);
        check("rst_clkcnt", clk_count_load, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.in_valid = 1'b0;
        s_if.in_real  = '0;
        s_if.in_imag  = '0;
        s_if.flush    = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        check_reset_outputs();

        // Full frame of back-to-back samples.
        start_frame();
        for (int i = 0; i < NPTS; i++) send(N'(i) << 16, '0, 1'b0);
        finish_frame(100);

        // Flush alone in IDLE must not start anything.
        flush_only();
        step();
        check("idle_flush_ignored", s_if.in_ready, 0);
        check("idle_count_held", sample_count, NPTS);

        // Short frame: three samples then a standalone flush.
        start_frame();
        for (int i = 0; i < 3; i++) send(N'($urandom), N'($urandom), 1'b0);
        flush_only();
        finish_frame(10);

        // Flush coincident with the fifth sample.
        start_frame();
        for (int i = 0; i < 4; i++) send(N'($urandom), N'($urandom), 1'b0);
        send(32'h1234_5678, 32'h8765_4321, 1'b1);
        finish_frame(5);

        // Gaps in in_valid, sign-magnitude corner values, start_load mid-frame.
        start_frame();
        send(32'h8000_0000, 32'h0000_0001, 1'b0);
        step(); step();
        send(32'h8002_0000, 32'h8000_0100, 1'b0);
        start_load = 1'b1;
        step();
        start_load = 1'b0;
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step(); step();
        send(32'h8000_0200, 32'h8000_01FF, 1'b0);
        flush_only();
        finish_frame(3);

        // Reset in the middle of a frame.
        start_frame();
        for (int i = 0; i < 200; i++) send(N'($urandom), N'($urandom), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs();
        check("rst_queue_empty", exp_q.size(), 0);
        repeat (20) step();
        check("rst_no_startfft", startfft, 0);
        check("rst_stays_idle", s_if.in_ready, 0);

        // Zero-sample frame after reset: pure padding.
        start_frame();
        flush_only();
        finish_frame(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
